// File: rtl/mac_acc_quant_if.sv
// Handshake bundle between the MAC stream, the quantiser and the activation writer.
// Carries the acc beat stream (no backpressure) and the valid/ready result queue.
interface mac_acc_quant_if #(
  parameter int WA = 22,
  parameter int WQ = 8
);
  logic          acc_vld_i;
  logic [WA-1:0] acc_i;
  logic          q_vld_o;
  logic [WQ-1:0] q_data_o;
  logic          q_ready_i;

  modport master (
    output acc_vld_i, acc_i, q_ready_i,
    input  q_vld_o, q_data_o
  );

  modport slave (
    input  acc_vld_i, acc_i, q_ready_i,
    output q_vld_o, q_data_o
  );
endinterface

// File: rtl/mac_acc_quant.sv
// Accumulates cfg_groups MAC partial sums plus bias, then round-shifts, clamps
// and queues 8-bit results. Ports: clk/rstn/clr, cfg_*, bias, bus (slave), busy_o, ovf_o.
module mac_acc_quant #(
  parameter int WA    = 22,
  parameter int WACC  = 32,
  parameter int WQ    = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   clr,
  input  logic [7:0]             cfg_groups,
  input  logic [4:0]             cfg_shift,
  input  logic                   cfg_relu,
  input  logic signed [WACC-1:0] bias,
  mac_acc_quant_if.slave         bus,
  output logic                   busy_o,
  output logic                   ovf_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int UMAX = (1 << WQ) - 1;
  localparam int SMAX = (1 << (WQ - 1)) - 1;
  localparam int SMIN = -(1 << (WQ - 1));
  localparam logic signed [WACC:0] L_UMAX = (WACC+1)'(UMAX);
  localparam logic signed [WACC:0] L_SMAX = (WACC+1)'(SMAX);
  localparam logic signed [WACC:0] L_SMIN = (WACC+1)'(SMIN);

  // stage A
  logic [7:0]             r_cnt;
  logic [7:0]             r_groups;
  logic [4:0]             r_shift;
  logic                   r_relu;
  logic signed [WACC-1:0] r_sum;
  logic                   r_a_vld;

  logic                   w_first;
  logic [7:0]             w_g;
  logic                   w_last;
  logic                   w_beat;
  logic signed [WACC-1:0] w_acc;
  logic signed [WACC-1:0] w_sum_nxt;

  assign w_first = (r_cnt == 8'd0);
  assign w_g     = !w_first ? r_groups :
                   (cfg_groups == 8'd0) ? 8'd1 : cfg_groups;
  assign w_last  = (r_cnt == w_g - 8'd1);
  assign w_beat  = bus.acc_vld_i & ~clr;
  assign w_acc   = {{(WACC-WA){bus.acc_i[WA-1]}}, bus.acc_i};
  assign w_sum_nxt = (w_first ? bias : r_sum) + w_acc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt    <= '0;
      r_groups <= '0;
      r_shift  <= '0;
      r_relu   <= 1'b0;
      r_sum    <= '0;
      r_a_vld  <= 1'b0;
    end else begin
      r_a_vld <= w_beat & w_last;
      if (clr) begin
        r_cnt <= '0;
      end else if (bus.acc_vld_i) begin
        if (w_first) begin
          r_groups <= w_g;
          r_shift  <= cfg_shift;
          r_relu   <= cfg_relu;
        end
        r_sum <= w_sum_nxt;
        r_cnt <= w_last ? 8'd0 : r_cnt + 8'd1;
      end
    end
  end

  // stage B: round-half-up shift in WACC+1 bits so the rounding add cannot wrap
  logic signed [WACC:0] w_ext;
  logic signed [WACC:0] w_rnd;
  logic signed [WACC:0] w_sh;
  logic [WQ-1:0]        w_q;

  assign w_ext = {r_sum[WACC-1], r_sum};
  assign w_rnd = (r_shift == 5'd0) ? w_ext :
                 w_ext + ((WACC+1)'(1) << (r_shift - 5'd1));
  assign w_sh  = w_rnd >>> r_shift;

  always_comb begin
    w_q = w_sh[WQ-1:0];
    unique case (1'b1)
      r_relu && (w_sh < 0):       w_q = '0;
      r_relu && (w_sh > L_UMAX):  w_q = UMAX[WQ-1:0];
      !r_relu && (w_sh > L_SMAX): w_q = SMAX[WQ-1:0];
      !r_relu && (w_sh < L_SMIN): w_q = SMIN[WQ-1:0];
      default:                    w_q = w_sh[WQ-1:0];
    endcase
  end

  logic [WQ-1:0] r_b;
  logic          r_b_vld;
  logic [WQ-1:0] r_c;
  logic          r_c_vld;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_b     <= '0;
      r_b_vld <= 1'b0;
      r_c     <= '0;
      r_c_vld <= 1'b0;
    end else begin
      r_b_vld <= r_a_vld;
      if (r_a_vld) r_b <= w_q;
      r_c_vld <= r_b_vld;
      if (r_b_vld) r_c <= r_b;
    end
  end

  // stage C: result FIFO
  logic [WQ-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_fcnt;
  logic          r_ovf;

  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_full = (r_fcnt == (AW+1)'(DEPTH));
  assign w_pop  = (r_fcnt != '0) & bus.q_ready_i;
  // a full FIFO still takes a push when the head leaves in the same cycle
  assign w_push = r_c_vld & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= r_c;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_fcnt <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_fcnt <= r_fcnt + (AW+1)'(1);
        2'b01:   r_fcnt <= r_fcnt - (AW+1)'(1);
        default: r_fcnt <= r_fcnt;
      endcase
      if (clr)
        r_ovf <= 1'b0;
      else if (r_c_vld & w_full & ~w_pop)
        r_ovf <= 1'b1;
    end
  end

  assign bus.q_vld_o  = (r_fcnt != '0);
  assign bus.q_data_o = bus.q_vld_o ? r_mem[r_rp] : '0;
  assign busy_o       = (r_cnt != 8'd0);
  assign ovf_o        = r_ovf;
endmodule

// File: tb/tb_mac_acc_quant.sv
// Self-checking bench for mac_acc_quant: directed scenarios plus randomized
// groups scored against an arithmetic reference model.
module tb_mac_acc_quant;
  logic              clk = 1'b0;
  logic              rstn;
  logic              clr;
  logic [7:0]        cfg_groups;
  logic [4:0]        cfg_shift;
  logic              cfg_relu;
  logic signed [31:0] bias;
  logic              busy;
  logic              ovf;

  mac_acc_quant_if #(.WA(22), .WQ(8)) bus();

  mac_acc_quant #(.WA(22), .WACC(32), .WQ(8), .DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .clr(clr),
    .cfg_groups(cfg_groups), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .bias(bias), .bus(bus), .busy_o(busy), .ovf_o(ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] obs_q[$];
  int         obs_t[$];

  always @(posedge clk) begin
    if (rstn && bus.q_vld_o && bus.q_ready_i) begin
      obs_q.push_back(bus.q_data_o);
      obs_t.push_back(cyc);
    end
    cyc++;
  end

  function automatic logic [7:0] model(int s, int sh, bit relu);
    longint r;
    r = (sh == 0) ? longint'(s) : (longint'(s) + (64'sd1 <<< (sh - 1))) >>> sh;
    if (relu) begin
      if (r < 0) r = 0;
      if (r > 255) r = 255;
    end else begin
      if (r < -128) r = -128;
      if (r > 127) r = 127;
    end
    return 8'(r);
  endfunction

  function automatic int rnd22();
    logic signed [21:0] t;
    t = 22'($urandom);
    return int'(t);
  endfunction

  task automatic send_beat(int v, int g, int sh, bit relu, int b);
    bus.acc_vld_i = 1'b1;
    bus.acc_i = 22'(v);
    cfg_groups = 8'(g);
    cfg_shift = 5'(sh);
    cfg_relu = relu;
    bias = b;
    @(negedge clk);
    bus.acc_vld_i = 1'b0;
  endtask

  task automatic wait_obs(int n, int budget);
    for (int i = 0; i < budget && obs_q.size() < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0; clr = 1'b0;
    bus.acc_vld_i = 1'b0; bus.acc_i = '0; bus.q_ready_i = 1'b0;
    cfg_groups = 8'd1; cfg_shift = '0; cfg_relu = 1'b0; bias = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.q_vld_o, bus.q_data_o, busy, ovf} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got vld=%0b data=%0d busy=%0b ovf=%0b expected all 0",
               bus.q_vld_o, bus.q_data_o, busy, ovf);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_latency();
    bus.q_ready_i = 1'b0;
    obs_q.delete(); obs_t.delete();
    send_beat(100, 2, 2, 1'b1, 10);
    send_beat(50, 7, 0, 1'b0, 999);
    repeat (2) @(negedge clk);
    checks++;
    if (bus.q_vld_o !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: q_vld_o=%0b expected 0 two cycles after beat", bus.q_vld_o);
    end
    @(negedge clk);
    checks++;
    if (bus.q_vld_o !== 1'b1 || bus.q_data_o !== 8'd40) begin
      errors++;
      $display("FAIL latency_result: vld=%0b data=%0d expected vld=1 data=40",
               bus.q_vld_o, bus.q_data_o);
    end
    @(negedge clk);
    checks++;
    if (bus.q_data_o !== 8'd40) begin
      errors++;
      $display("FAIL hold_stable: data=%0d expected 40", bus.q_data_o);
    end
    bus.q_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.q_vld_o !== 1'b0 || obs_q.size() != 1) begin
      errors++;
      $display("FAIL pop_single: vld=%0b pops=%0d expected vld=0 pops=1",
               bus.q_vld_o, obs_q.size());
    end
  endtask

  task automatic test_saturation();
    logic [7:0] exp[3];
    exp[0] = 8'h00; exp[1] = 8'h80; exp[2] = 8'hFF;
    bus.q_ready_i = 1'b1;
    obs_q.delete(); obs_t.delete();
    send_beat(-300, 1, 0, 1'b1, 0);
    send_beat(-300, 1, 0, 1'b0, 0);
    send_beat(1000, 0, 0, 1'b1, 0);
    wait_obs(3, 20);
    checks++;
    if (obs_q.size() != 3) begin
      errors++;
      $display("FAIL sat_count: got %0d results expected 3", obs_q.size());
    end
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL sat_value[%0d]: got 0x%02h expected 0x%02h", i, obs_q[i], exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp[$];
    int v;
    bus.q_ready_i = 1'b1;
    obs_q.delete(); obs_t.delete();
    for (int i = 0; i < 100; i++) begin
      v = rnd22();
      exp.push_back(model(v, 0, 1'b0));
      send_beat(v, 1, 0, 1'b0, 0);
    end
    wait_obs(100, 50);
    checks++;
    if (obs_q.size() != 100) begin
      errors++;
      $display("FAIL b2b_count: got %0d expected 100", obs_q.size());
    end else begin
      for (int i = 0; i < 100; i++) begin
        checks++;
        if (obs_q[i] !== exp[i]) begin
          errors++;
          $display("FAIL b2b_value[%0d]: got %0d expected %0d", i, obs_q[i], exp[i]);
        end
      end
      checks++;
      if (obs_t[99] - obs_t[0] != 99) begin
        errors++;
        $display("FAIL b2b_gapless: span %0d cycles expected 99", obs_t[99] - obs_t[0]);
      end
    end
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ovf: got %0b expected 0", ovf);
    end
  endtask

  task automatic test_overflow();
    bus.q_ready_i = 1'b0;
    obs_q.delete(); obs_t.delete();
    for (int i = 1; i <= 5; i++) send_beat(i, 1, 0, 1'b0, 0);
    repeat (6) @(negedge clk);
    checks++;
    if (ovf !== 1'b1 || bus.q_vld_o !== 1'b1 || bus.q_data_o !== 8'd1) begin
      errors++;
      $display("FAIL ovf_full: ovf=%0b vld=%0b data=%0d expected ovf=1 vld=1 data=1",
               ovf, bus.q_vld_o, bus.q_data_o);
    end
    bus.q_ready_i = 1'b1;
    wait_obs(4, 20);
    repeat (3) @(negedge clk);
    checks++;
    if (obs_q.size() != 4 || bus.q_vld_o !== 1'b0) begin
      errors++;
      $display("FAIL ovf_drain_count: got %0d results vld=%0b expected 4 vld=0",
               obs_q.size(), bus.q_vld_o);
    end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== 8'(i + 1)) begin
        errors++;
        $display("FAIL ovf_drain[%0d]: got %0d expected %0d", i, obs_q[i], i + 1);
      end
    end
  endtask

  task automatic test_clr();
    bus.q_ready_i = 1'b1;
    obs_q.delete(); obs_t.delete();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL clr_ovf: got %0b expected 0", ovf);
    end
    send_beat(7, 3, 0, 1'b0, 0);
    send_beat(7, 3, 0, 1'b0, 0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL clr_busy_before: got %0b expected 1", busy);
    end
    clr = 1'b1;
    bus.acc_vld_i = 1'b1;
    bus.acc_i = 22'd7;
    @(negedge clk);
    clr = 1'b0;
    bus.acc_vld_i = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL clr_busy_after: got %0b expected 0", busy);
    end
    send_beat(1, 3, 0, 1'b0, 0);
    send_beat(2, 3, 0, 1'b0, 0);
    send_beat(3, 3, 0, 1'b0, 0);
    repeat (8) @(negedge clk);
    checks++;
    if (obs_q.size() != 1 || (obs_q.size() == 1 && obs_q[0] !== 8'd6) || busy !== 1'b0) begin
      errors++;
      $display("FAIL clr_result: got %0d results first=%0d busy=%0b expected 1 result 6 busy=0",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 8'd0, busy);
    end
  endtask

  task automatic test_reset_mid();
    bus.q_ready_i = 1'b0;
    obs_q.delete(); obs_t.delete();
    send_beat(11, 1, 0, 1'b0, 0);
    send_beat(12, 1, 0, 1'b0, 0);
    repeat (5) @(negedge clk);
    send_beat(1, 2, 0, 1'b0, 0);
    checks++;
    if (busy !== 1'b1 || bus.q_vld_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_setup: busy=%0b vld=%0b expected 1 1", busy, bus.q_vld_o);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({bus.q_vld_o, bus.q_data_o, busy, ovf} !== 11'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs: vld=%0b data=%0d busy=%0b ovf=%0b expected all 0",
               bus.q_vld_o, bus.q_data_o, busy, ovf);
    end
    @(negedge clk);
    rstn = 1'b1;
    bus.q_ready_i = 1'b1;
    obs_q.delete(); obs_t.delete();
    send_beat(5, 1, 0, 1'b0, 0);
    wait_obs(1, 20);
    repeat (3) @(negedge clk);
    checks++;
    if (obs_q.size() != 1 || (obs_q.size() == 1 && obs_q[0] !== 8'd5)) begin
      errors++;
      $display("FAIL rst_after: got %0d results first=%0d expected 1 result 5",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 8'd0);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp[$];
    bit done = 1'b0;
    obs_q.delete(); obs_t.delete();
    fork
      begin
        for (int grp = 0; grp < 40; grp++) begin
          int g, eff, sh, b, s, v;
          bit relu;
          g = $urandom_range(0, 4);
          eff = (g == 0) ? 1 : g;
          sh = $urandom_range(0, 14);
          relu = 1'($urandom);
          b = int'($urandom) >>> $urandom_range(8, 31);
          s = b;
          for (int k = 0; k < eff; k++) begin
            v = rnd22();
            s += v;
            if (k == 0) send_beat(v, g, sh, relu, b);
            else send_beat(v, $urandom_range(0, 9), $urandom_range(0, 31), 1'($urandom), int'($urandom));
            repeat (2) @(negedge clk);
          end
          exp.push_back(model(s, sh, relu));
        end
        done = 1'b1;
      end
      begin
        int n = 0;
        while (!done) begin
          bus.q_ready_i = n[0] | 1'($urandom);
          n++;
          @(negedge clk);
        end
        bus.q_ready_i = 1'b1;
      end
    join
    wait_obs(40, 40);
    checks++;
    if (obs_q.size() != 40) begin
      errors++;
      $display("FAIL rand_count: got %0d expected 40", obs_q.size());
    end
    for (int i = 0; i < 40 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL rand_value[%0d]: got %0d expected %0d", i, obs_q[i], exp[i]);
      end
    end
    checks++;
    if (ovf !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rand_flags: ovf=%0b busy=%0b expected 0 0", ovf, busy);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_latency();
    test_saturation();
    test_back_to_back();
    test_overflow();
    test_clr();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
